// File: rtl/mig_app_pkg.sv
// Shared app_* interface constants for the MIG user-interface responder and its initiator.
package mig_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int CMD_W      = 3;
  localparam int MIG_DATA_W = 128;
  localparam int MIG_MASK_W = MIG_DATA_W / 8;

endpackage

// File: rtl/app_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty depend only on flopped state.
module app_sync_fifo
  import mig_app_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mig_app_responder.sv
// On-chip stand-in for the MIG 7-series app_* interface: queued commands and write beats,
// byte-enable RAM, fixed-latency in-order read return.
module mig_app_responder
  import mig_app_pkg::*;
#(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = MIG_DATA_W,
  parameter int MEM_AW       = 10,
  parameter int FIFO_AW      = 2,
  parameter int RD_LAT       = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_PERIOD = 0
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  output logic                init_calib_complete,
  input  logic [ADDR_W-1:0]   app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CMDQ_W = CMD_W + MEM_AW;
  localparam int WDFQ_W = MASK_W + DATA_W;
  localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);

  logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMDQ_W-1:0] cmd_din, cmd_dout;
  logic              wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic [WDFQ_W-1:0] wdf_din, wdf_dout;

  logic [CMD_W-1:0]  head_cmd;
  logic [MEM_AW-1:0] head_idx;
  logic [MASK_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic              ram_we, rd_issue, stall;

  logic [DATA_W-1:0] ram [1 << MEM_AW];
  logic [DATA_W-1:0] ram_rd_q, rd_tail;

  logic              calib_q, calib_d;
  logic [CAL_W-1:0]  calib_cnt_q, calib_cnt_d;
  logic [RD_LAT-2:0] vld_q, vld_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              unused_inputs;

  assign unused_inputs = ^{app_addr, app_wdf_end};

  assign init_calib_complete = calib_q;
  assign app_rdy             = calib_q && !cmd_full && !stall;
  assign app_wdf_rdy         = calib_q && !wdf_full;
  assign app_rd_data         = rd_data_q;
  assign app_rd_data_valid   = rd_valid_q;
  assign app_rd_data_end     = rd_valid_q;

  // Only the beat index is queued; upper address bits fold the address space onto the RAM.
  assign cmd_push = app_en && app_rdy;
  assign cmd_din  = {app_cmd, app_addr[MEM_AW+2:3]};
  assign wdf_push = app_wdf_wren && app_wdf_rdy;
  assign wdf_din  = {app_wdf_mask, app_wdf_data};

  assign head_cmd = cmd_dout[CMDQ_W-1:MEM_AW];
  assign head_idx = cmd_dout[MEM_AW-1:0];
  assign wr_mask  = wdf_dout[WDFQ_W-1:DATA_W];
  assign wr_data  = wdf_dout[DATA_W-1:0];

  app_sync_fifo #(.WIDTH(CMDQ_W), .AW(FIFO_AW)) u_cmd_fifo (
    .clk   (ui_clk),
    .rst   (ui_clk_sync_rst),
    .push  (cmd_push),
    .din   (cmd_din),
    .pop   (cmd_pop),
    .dout  (cmd_dout),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  app_sync_fifo #(.WIDTH(WDFQ_W), .AW(FIFO_AW)) u_wdf_fifo (
    .clk   (ui_clk),
    .rst   (ui_clk_sync_rst),
    .push  (wdf_push),
    .din   (wdf_din),
    .pop   (wdf_pop),
    .dout  (wdf_dout),
    .full  (wdf_full),
    .empty (wdf_empty)
  );

  // A write at the head waits for its data beat, which keeps everything behind it in order.
  always_comb begin
    cmd_pop  = 1'b0;
    wdf_pop  = 1'b0;
    ram_we   = 1'b0;
    rd_issue = 1'b0;
    if (!cmd_empty) begin
      case (head_cmd)
        CMD_WRITE: begin
          if (!wdf_empty) begin
            cmd_pop = 1'b1;
            wdf_pop = 1'b1;
            ram_we  = 1'b1;
          end
        end
        CMD_READ: begin
          cmd_pop  = 1'b1;
          rd_issue = 1'b1;
        end
        default: cmd_pop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ram_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wr_mask[b]) ram[head_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_issue) ram_rd_q <= ram[head_idx];
  end

  generate
    if (RD_LAT > 2) begin : g_dpipe
      logic [DATA_W-1:0] pipe_q [RD_LAT-2];
      always_ff @(posedge ui_clk) begin
        pipe_q[0] <= ram_rd_q;
        for (int i = 1; i < RD_LAT - 2; i++) pipe_q[i] <= pipe_q[i-1];
      end
      assign rd_tail = pipe_q[RD_LAT-3];
    end else begin : g_no_dpipe
      assign rd_tail = ram_rd_q;
    end
  endgenerate

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
      always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (calib_q) begin
          stall_cnt_d = (stall_cnt_q == STALL_W'(STALL_PERIOD - 1)) ? '0 : stall_cnt_q + STALL_W'(1);
        end
      end
      always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) stall_cnt_q <= '0;
        else                 stall_cnt_q <= stall_cnt_d;
      end
      assign stall = calib_q && (stall_cnt_q == STALL_W'(STALL_PERIOD - 1));
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  always_comb begin
    calib_cnt_d = calib_q ? calib_cnt_q : calib_cnt_q + CAL_W'(1);
    calib_d     = calib_q || (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1));
    vld_d       = vld_q << 1;
    vld_d[0]    = rd_issue;
    rd_valid_d  = vld_q[RD_LAT-2];
    rd_data_d   = vld_q[RD_LAT-2] ? rd_tail : rd_data_q;
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      calib_q     <= 1'b0;
      calib_cnt_q <= '0;
      vld_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      calib_q     <= calib_d;
      calib_cnt_q <= calib_cnt_d;
      vld_q       <= vld_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule
